// File: rtl/mpadd_pkg.sv
`default_nettype none
// ---- mpadd_pkg : shared constants and state type for mpadd_256 | rev 1.0 ----
package mpadd_pkg;

   localparam int WIDTH  = 256;
   localparam int WORD_W = 32;
   localparam int NWORDS = WIDTH / WORD_W;
   localparam int CNT_W  = $clog2(NWORDS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/mpadd_word_add.sv
`default_nettype none
// ---- mpadd_word_add : W-bit combinational adder with carry in/out | rev 1.0 ----
module mpadd_word_add #(
   parameter int W = 32
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] sum,
   output logic         cout
);

   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule
`default_nettype wire

// File: rtl/mpadd_256.sv
`default_nettype none
// ---- mpadd_256 : word-serial 256-bit unsigned adder, 257-bit registered sum | rev 1.0 ----
module mpadd_256
   import mpadd_pkg::*;
(
   input  logic             CLK,
   input  logic             RST_N,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             write,
   input  logic             start,
   output logic [WIDTH:0]   s_out,
   output logic             ready
);

   state_t             r_state;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [WIDTH-1:0]   r_sum;
   logic               r_carry;
   logic [CNT_W-1:0]   r_cnt;

   logic [WORD_W-1:0]  w_sum;
   logic               w_cout;

   mpadd_word_add #(
      .W (WORD_W)
   ) u_word_add (
      .a    (r_a[WORD_W-1:0]),
      .b    (r_b[WORD_W-1:0]),
      .cin  (r_carry),
      .sum  (w_sum),
      .cout (w_cout)
   );

   // Operands rotate rather than shift so that after NWORDS steps they are
   // back in place and a repeated start recomputes the same sum.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_state <= IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
         s_out   <= '0;
         ready   <= 1'b0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               if (write) begin
                  r_a     <= a_in;
                  r_b     <= b_in;
                  ready   <= 1'b0;
                  r_state <= IDLE;
               end else if (start) begin
                  r_carry <= 1'b0;
                  r_cnt   <= '0;
                  ready   <= 1'b0;
                  r_state <= BUSY;
               end
            end
            BUSY: begin
               r_a     <= {r_a[WORD_W-1:0], r_a[WIDTH-1:WORD_W]};
               r_b     <= {r_b[WORD_W-1:0], r_b[WIDTH-1:WORD_W]};
               r_sum   <= {w_sum, r_sum[WIDTH-1:WORD_W]};
               r_carry <= w_cout;
               if (r_cnt == CNT_W'(NWORDS - 1)) begin
                  r_cnt   <= '0;
                  s_out   <= {w_cout, w_sum, r_sum[WIDTH-1:WORD_W]};
                  ready   <= 1'b1;
                  r_state <= DONE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mpadd_256.sv
`default_nettype none
// ---- tb_mpadd_256 : directed and LFSR regression bench for mpadd_256 | rev 1.0 ----
module tb_mpadd_256;

   logic         CLK;
   logic         RST_N;
   logic [255:0] a_in;
   logic [255:0] b_in;
   logic         write;
   logic         start;
   logic [256:0] s_out;
   logic         ready;

   int pass_cnt;
   int total_cnt;

   localparam logic [255:0] ONES = {256{1'b1}};
   localparam int LAT_BOUND = 20;

   mpadd_256 dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .a_in  (a_in),
      .b_in  (b_in),
      .write (write),
      .start (start),
      .s_out (s_out),
      .ready (ready)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic do_write(input logic [255:0] a, input logic [255:0] b);
      @(negedge CLK);
      a_in  = a;
      b_in  = b;
      write = 1'b1;
      @(negedge CLK);
      write = 1'b0;
   endtask

   task automatic do_start();
      @(negedge CLK);
      start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
   endtask

   // Counts edges after the start-sampling edge until ready rises.
   task automatic wait_ready(output int lat);
      lat = 0;
      while (!ready && lat < LAT_BOUND) begin
         @(negedge CLK);
         lat++;
      end
   endtask

   task automatic test_reset();
      RST_N = 1'b0;
      repeat (2) @(negedge CLK);
      RST_N = 1'b1;
      @(negedge CLK);
      total_cnt++;
      if (s_out !== 257'h0 || ready !== 1'b0)
         $display("FAIL reset_state: s_out=%h ready=%b required s_out=0 ready=0", s_out, ready);
      else pass_cnt++;
      repeat (10) @(negedge CLK);
      total_cnt++;
      if (ready !== 1'b0)
         $display("FAIL idle_ready: ready=%b required 0", ready);
      else pass_cnt++;
   endtask

   task automatic test_full_carry();
      int lat;
      do_write(ONES, 256'h1);
      do_start();
      wait_ready(lat);
      total_cnt++;
      if (lat !== 8)
         $display("FAIL full_carry_latency: got %0d required 8", lat);
      else pass_cnt++;
      total_cnt++;
      if (s_out !== {1'b1, 256'h0})
         $display("FAIL full_carry_sum: got %h required %h", s_out, {1'b1, 256'h0});
      else pass_cnt++;
   endtask

   task automatic test_word_boundary();
      int lat;
      do_write(256'hFFFF_FFFF, 256'h1);
      do_start();
      wait_ready(lat);
      total_cnt++;
      if (ready !== 1'b1 || s_out !== 257'h1_0000_0000)
         $display("FAIL word_boundary: ready=%b got %h required %h", ready, s_out, 257'h1_0000_0000);
      else pass_cnt++;
      do_write(ONES, ONES);
      do_start();
      wait_ready(lat);
      total_cnt++;
      if (ready !== 1'b1 || s_out !== {1'b1, {255{1'b1}}, 1'b0})
         $display("FAIL max_plus_max: ready=%b got %h required %h", ready, s_out, {1'b1, {255{1'b1}}, 1'b0});
      else pass_cnt++;
   endtask

   task automatic test_ready_handshake();
      int lat;
      do_write(256'h5, 256'h7);
      total_cnt++;
      if (ready !== 1'b0)
         $display("FAIL handshake_ready_clear: ready=%b required 0", ready);
      else pass_cnt++;
      // Stale result must never appear with ready high before the new one.
      @(negedge CLK);
      start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      lat = 0;
      while (!ready && lat < LAT_BOUND) begin
         @(negedge CLK);
         lat++;
      end
      total_cnt++;
      if (ready !== 1'b1 || s_out !== 257'hC)
         $display("FAIL handshake_new_sum: ready=%b got %h required c", ready, s_out);
      else pass_cnt++;
   endtask

   task automatic test_busy_start();
      int lat;
      do_write({224'h0, 32'h8000_0000}, {224'h0, 32'h8000_0001});
      do_start();
      repeat (3) @(negedge CLK);
      start = 1'b1;
      write = 1'b1;
      a_in  = 256'h1;
      b_in  = 256'h1;
      @(negedge CLK);
      start = 1'b0;
      write = 1'b0;
      lat = 4;
      while (!ready && lat < LAT_BOUND) begin
         @(negedge CLK);
         lat++;
      end
      total_cnt++;
      if (lat !== 8)
         $display("FAIL busy_start_latency: got %0d required 8", lat);
      else pass_cnt++;
      total_cnt++;
      if (s_out !== 257'h1_0000_0001)
         $display("FAIL busy_start_sum: got %h required 100000001", s_out);
      else pass_cnt++;
      do_start();
      wait_ready(lat);
      total_cnt++;
      if (lat !== 8 || s_out !== 257'h1_0000_0001)
         $display("FAIL restart_same_sum: lat=%0d got %h required lat=8 sum=100000001", lat, s_out);
      else pass_cnt++;
   endtask

   task automatic test_reset_midop();
      int lat;
      logic [255:0] ga;
      logic [255:0] gb;
      logic [256:0] exp_sum;
      do_write(ONES, ONES);
      do_start();
      repeat (3) @(negedge CLK);
      RST_N = 1'b0;
      @(negedge CLK);
      RST_N = 1'b1;
      total_cnt++;
      if (ready !== 1'b0 || s_out !== 257'h0)
         $display("FAIL reset_midop: ready=%b s_out=%h required ready=0 s_out=0", ready, s_out);
      else pass_cnt++;
      repeat (12) @(negedge CLK);
      total_cnt++;
      if (ready !== 1'b0)
         $display("FAIL reset_midop_no_flag: ready=%b required 0", ready);
      else pass_cnt++;
      ga = 256'h6B17D1F2E12C4247F8BCE6E563A440F277037D812DEB33A0F4A13945D898C296;
      gb = 256'h4FE342E2FE1A7F9B8EE7EB4A7C0F9E162BCE33576B315ECECBB6406837BF51F5;
      exp_sum = {1'b0, ga} + {1'b0, gb};
      do_write(ga, gb);
      do_start();
      wait_ready(lat);
      total_cnt++;
      if (ready !== 1'b1 || s_out !== exp_sum)
         $display("FAIL post_reset_sum: ready=%b got %h required %h", ready, s_out, exp_sum);
      else pass_cnt++;
   endtask

   function automatic logic [255:0] lfsr_step(input logic [255:0] s);
      logic fb;
      fb = s[255] ^ s[253] ^ s[250] ^ s[245];
      return {s[254:0], fb};
   endfunction

   task automatic test_random();
      logic [255:0] lfsr;
      logic [255:0] ra;
      logic [255:0] rb;
      logic [256:0] exp_sum;
      int lat;
      lfsr = 256'hACE1_2468_9BDF_1357_0F0F_F0F0_DEAD_BEEF_CAFE_F00D_1234_5678_9ABC_DEF0_0246_8ACE;
      for (int n = 0; n < 1000; n++) begin
         for (int k = 0; k < 61; k++) lfsr = lfsr_step(lfsr);
         ra = lfsr;
         for (int k = 0; k < 67; k++) lfsr = lfsr_step(lfsr);
         rb = lfsr;
         exp_sum = {1'b0, ra} + {1'b0, rb};
         do_write(ra, rb);
         do_start();
         wait_ready(lat);
         total_cnt++;
         if (ready !== 1'b1 || lat !== 8 || s_out !== exp_sum)
            $display("FAIL random_%0d: ready=%b lat=%0d got %h required %h", n, ready, lat, s_out, exp_sum);
         else pass_cnt++;
      end
   endtask

   initial begin
      pass_cnt  = 0;
      total_cnt = 0;
      RST_N = 1'b0;
      a_in  = '0;
      b_in  = '0;
      write = 1'b0;
      start = 1'b0;
      test_reset();
      test_full_carry();
      test_word_boundary();
      test_ready_handshake();
      test_busy_start();
      test_reset_midop();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
`default_nettype wire
